// File: rtl/friscv_pmp_checker_if.sv
// friscv_pmp_checker_if: imem/dmem check request and response handshakes
interface friscv_pmp_checker_if #(
  parameter int AXI_ADDR_W = 32
);
  logic                  imem_req_valid;
  logic                  imem_req_ready;
  logic [AXI_ADDR_W-1:0] imem_req_addr;
  logic                  imem_rsp_valid;
  logic                  imem_rsp_allow;
  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic [AXI_ADDR_W-1:0] dmem_req_addr;
  logic                  dmem_req_wr;
  logic                  dmem_rsp_valid;
  logic                  dmem_rsp_allow;
  modport master (
    output imem_req_valid, imem_req_addr, dmem_req_valid, dmem_req_addr, dmem_req_wr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_allow, dmem_req_ready, dmem_rsp_valid, dmem_rsp_allow
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, dmem_req_valid, dmem_req_addr, dmem_req_wr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_allow, dmem_req_ready, dmem_rsp_valid, dmem_rsp_allow
  );
endinterface

// File: rtl/friscv_pmp_checker.sv
// friscv_pmp_checker: sequential PMP checker, one entry per cycle, shared by imem and dmem
module friscv_pmp_checker #(
  parameter int XLEN       = 32,
  parameter int AXI_ADDR_W = 32,
  parameter int NB_REGION  = 16
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      priv_u,
  input  logic                      cfg_update,
  input  logic [NB_REGION*8-1:0]    pmpcfg,
  input  logic [NB_REGION*XLEN-1:0] pmpaddr,
  friscv_pmp_checker_if.slave       bus,
  output logic                      busy
);
  localparam int IW = NB_REGION > 1 ? $clog2(NB_REGION) : 1;
  localparam int AW = XLEN + 2;
  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;
  state_t                state, state_nxt;
  logic [IW-1:0]         idx, idx_m1;
  logic                  rr, side, priv, allow_q;
  logic [1:0]            acc;
  logic [AXI_ADDR_W-1:0] addr;
  logic [7:0]            cfg;
  logic [XLEN-1:0]       cur, prev;
  logic [AW-1:0]         a, hi, lo, nap, nmask;
  logic                  hit, last, allow, gnt_i, gnt_d;
  assign gnt_i  = bus.imem_req_valid && (!bus.dmem_req_valid || !rr);
  assign gnt_d  = bus.dmem_req_valid && (!bus.imem_req_valid || rr);
  assign idx_m1 = idx - 1'b1;
  assign cfg    = pmpcfg[8*int'(idx) +: 8];
  assign cur    = pmpaddr[XLEN*int'(idx) +: XLEN];
  assign prev   = idx == '0 ? '0 : pmpaddr[XLEN*int'(idx_m1) +: XLEN];
  assign a      = AW'(addr);
  assign hi     = {cur, 2'b00};
  assign lo     = {prev, 2'b00};
  // x ^ (x+1) over {pmpaddr,11} yields exactly the NAPOT size-1 mask, all-ones included
  assign nap    = {cur, 2'b11};
  assign nmask  = ~(nap ^ (nap + 1'b1));
  assign hit    = cfg[4:3] == 2'd1 ? (lo < hi && a >= lo && a < hi) :
                  cfg[4:3] == 2'd2 ? a[AW-1:2] == cur :
                  cfg[4:3] == 2'd3 ? (a & nmask) == (hi & nmask) : 1'b0;
  assign allow  = hit ? ((!priv && !cfg[7]) || cfg[acc]) : !priv;
  assign last   = idx == IW'(NB_REGION - 1);
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state == IDLE ? ((gnt_i || gnt_d) ? SCAN : IDLE) :
                state == SCAN ? ((!cfg_update && (hit || last)) ? RESP : SCAN) : IDLE;
  end
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      idx     <= '0;
      rr      <= 1'b0;
      side    <= 1'b0;
      priv    <= 1'b0;
      acc     <= 2'd0;
      addr    <= '0;
      allow_q <= 1'b0;
    end else if (state == IDLE && (gnt_i || gnt_d)) begin
      idx  <= '0;
      rr   <= gnt_i;
      side <= gnt_d;
      priv <= priv_u;
      acc  <= gnt_d ? {1'b0, bus.dmem_req_wr} : 2'd2;
      addr <= gnt_d ? bus.dmem_req_addr : bus.imem_req_addr;
    end else if (state == SCAN) begin
      if (cfg_update) idx <= '0;
      else if (hit || last) allow_q <= allow;
      else idx <= idx + 1'b1;
    end
  end
  always_comb begin
    bus.imem_req_ready = state == IDLE;
    bus.dmem_req_ready = state == IDLE;
    bus.imem_rsp_valid = state == RESP && !side;
    bus.dmem_rsp_valid = state == RESP && side;
    bus.imem_rsp_allow = state == RESP && !side && allow_q;
    bus.dmem_rsp_allow = state == RESP && side && allow_q;
    busy               = state != IDLE;
  end
endmodule

// File: tb/tb_friscv_pmp_checker.sv
// tb_friscv_pmp_checker: directed and randomized checks against a behavioural PMP model
module tb_friscv_pmp_checker;
  localparam int NB = 16;
  logic aclk = 1'b0, areset = 1'b1, priv_u = 1'b0, cfg_update = 1'b0, busy;
  logic [7:0] cfg_a[NB];
  logic [31:0] adr_a[NB];
  logic [NB*8-1:0] pmpcfg;
  logic [NB*32-1:0] pmpaddr;
  int n_chk = 0, n_fail = 0;
  bit rr_m = 1'b0;
  friscv_pmp_checker_if #(.AXI_ADDR_W(32)) bus();
  friscv_pmp_checker #(.XLEN(32), .AXI_ADDR_W(32), .NB_REGION(NB)) dut (
    .aclk(aclk), .areset(areset), .priv_u(priv_u), .cfg_update(cfg_update),
    .pmpcfg(pmpcfg), .pmpaddr(pmpaddr), .bus(bus), .busy(busy)
  );
  always #5 aclk = ~aclk;
  always_comb begin
    pmpcfg  = '0;
    pmpaddr = '0;
    for (int i = 0; i < NB; i++) begin
      pmpcfg[8*i +: 8]   = cfg_a[i];
      pmpaddr[32*i +: 32] = adr_a[i];
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic clr();
    for (int i = 0; i < NB; i++) begin
      cfg_a[i] = 8'h00;
      adr_a[i] = 32'h0;
    end
  endtask
  // acc: 0 read, 1 write, 2 execute; k = index of deciding entry (NB-1 on miss)
  function automatic void model(input logic [31:0] a, input int acc, input bit pu, output bit ok, output int k);
    longint aa, hi, lo, sz;
    int t;
    bit hit;
    ok = !pu;
    k  = NB - 1;
    aa = longint'(a);
    for (int i = 0; i < NB; i++) begin
      hit = 1'b0;
      hi  = longint'(adr_a[i]) * 4;
      lo  = 0;
      if (i > 0) lo = longint'(adr_a[i-1]) * 4;
      case (cfg_a[i][4:3])
        2'd1: hit = lo < hi && aa >= lo && aa < hi;
        2'd2: hit = aa / 4 == longint'(adr_a[i]);
        2'd3: begin
          t = 0;
          while (t < 32 && adr_a[i][t]) t++;
          sz  = longint'(1) << (t + 3);
          hit = aa / sz == hi / sz;
        end
        default: hit = 1'b0;
      endcase
      if (hit) begin
        ok = (!pu && !cfg_a[i][7]) || cfg_a[i][acc];
        k  = i;
        return;
      end
    end
  endfunction
  task automatic wait_rsp(input bit side, input bit exp_ok, input int exp_lat, input string tag, input int start);
    int lat = start;
    while (!(side ? bus.dmem_rsp_valid : bus.imem_rsp_valid) && lat < 100) begin
      if (side ? bus.imem_rsp_valid : bus.dmem_rsp_valid) check({tag, "_stray"}, 1, 0);
      @(negedge aclk);
      lat++;
    end
    check({tag, "_lat"}, lat, exp_lat);
    check({tag, "_allow"}, side ? bus.dmem_rsp_allow : bus.imem_rsp_allow, exp_ok);
    @(negedge aclk);
    check({tag, "_pulse"}, side ? bus.dmem_rsp_valid : bus.imem_rsp_valid, 0);
  endtask
  task automatic single(input bit side, input logic [31:0] a, input bit wr, input bit exp_ok, input int exp_lat, input string tag);
    if (side) begin
      bus.dmem_req_valid = 1'b1;
      bus.dmem_req_addr  = a;
      bus.dmem_req_wr    = wr;
    end else begin
      bus.imem_req_valid = 1'b1;
      bus.imem_req_addr  = a;
    end
    @(negedge aclk);
    bus.imem_req_valid = 1'b0;
    bus.dmem_req_valid = 1'b0;
    rr_m = !side;
    wait_rsp(side, exp_ok, exp_lat, tag, 1);
  endtask
  task automatic both(input logic [31:0] ia, input logic [31:0] da, input bit dwr, input bit first,
                      input bit i_ok, input int i_lat, input bit d_ok, input int d_lat, input string tag);
    bus.imem_req_valid = 1'b1;
    bus.imem_req_addr  = ia;
    bus.dmem_req_valid = 1'b1;
    bus.dmem_req_addr  = da;
    bus.dmem_req_wr    = dwr;
    @(negedge aclk);
    if (first) bus.dmem_req_valid = 1'b0;
    else bus.imem_req_valid = 1'b0;
    wait_rsp(first, first ? d_ok : i_ok, first ? d_lat : i_lat, {tag, "_1st"}, 1);
    @(negedge aclk);
    bus.imem_req_valid = 1'b0;
    bus.dmem_req_valid = 1'b0;
    wait_rsp(!first, first ? i_ok : d_ok, first ? i_lat : d_lat, {tag, "_2nd"}, 1);
    rr_m = first;
  endtask
  initial begin
    bit i_ok, d_ok, side, wr, seen;
    int ik, dk;
    logic [31:0] ia, da;
    bus.imem_req_valid = 1'b0;
    bus.imem_req_addr  = '0;
    bus.dmem_req_valid = 1'b0;
    bus.dmem_req_addr  = '0;
    bus.dmem_req_wr    = 1'b0;
    clr();
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    check("rst_iready", bus.imem_req_ready, 1);
    check("rst_dready", bus.dmem_req_ready, 1);
    check("rst_irsp", bus.imem_rsp_valid, 0);
    check("rst_drsp", bus.dmem_rsp_valid, 0);
    check("rst_busy", busy, 0);
    both(32'h100, 32'h200, 1'b0, rr_m, 1'b1, NB + 1, 1'b1, NB + 1, "rr_a");
    single(1'b0, 32'h300, 1'b0, 1'b1, NB + 1, "rr_i");
    both(32'h100, 32'h200, 1'b1, rr_m, 1'b1, NB + 1, 1'b1, NB + 1, "rr_b");
    clr();
    adr_a[3] = 32'h13FF;
    cfg_a[3] = 8'h19;
    priv_u   = 1'b1;
    single(1'b1, 32'h5000, 1'b0, 1'b1, 5, "napot_ld");
    single(1'b1, 32'h5000, 1'b1, 1'b0, 5, "napot_st");
    single(1'b1, 32'h6000, 1'b0, 1'b0, NB + 1, "napot_miss");
    clr();
    adr_a[0] = 32'h400;
    adr_a[1] = 32'h800;
    cfg_a[1] = 8'h0C;
    single(1'b0, 32'h1000, 1'b0, 1'b1, 3, "tor_in");
    single(1'b0, 32'h2000, 1'b0, 1'b0, NB + 1, "tor_hi");
    single(1'b0, 32'h0FFC, 1'b0, 1'b0, NB + 1, "tor_lo");
    clr();
    priv_u   = 1'b0;
    adr_a[0] = 32'h40;
    cfg_a[0] = 8'h91;
    single(1'b0, 32'h100, 1'b0, 1'b0, 2, "lock_on");
    cfg_a[0] = 8'h11;
    single(1'b0, 32'h100, 1'b0, 1'b1, 2, "lock_off");
    clr();
    priv_u   = 1'b1;
    adr_a[1] = 32'h1000;
    cfg_a[1] = 8'h10;
    adr_a[2] = 32'h13FF;
    cfg_a[2] = 8'h1F;
    single(1'b1, 32'h4000, 1'b0, 1'b0, 3, "prio");
    clr();
    adr_a[3] = 32'h13FF;
    cfg_a[3] = 8'h19;
    bus.dmem_req_valid = 1'b1;
    bus.dmem_req_addr  = 32'h5000;
    bus.dmem_req_wr    = 1'b1;
    @(negedge aclk);
    bus.dmem_req_valid = 1'b0;
    rr_m = 1'b0;
    @(negedge aclk);
    cfg_a[3]   = 8'h1B;
    cfg_update = 1'b1;
    @(negedge aclk);
    cfg_update = 1'b0;
    wait_rsp(1'b1, 1'b1, 7, "cfgupd", 3);
    bus.dmem_req_valid = 1'b1;
    bus.dmem_req_wr    = 1'b0;
    @(negedge aclk);
    bus.dmem_req_valid = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_ready", bus.dmem_req_ready, 1);
    @(negedge aclk);
    areset = 1'b0;
    rr_m   = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge aclk);
      seen |= bus.dmem_rsp_valid | bus.imem_rsp_valid;
    end
    check("arst_norsp", seen, 0);
    for (int n = 0; n < 200; n++) begin
      if (n % 16 == 0)
        for (int i = 0; i < NB; i++) begin
          cfg_a[i] = 8'($urandom);
          adr_a[i] = $urandom_range(0, 15) == 0 ? 32'hFFFF_FFFF : 32'($urandom_range(0, 32'h3FF));
        end
      priv_u = 1'($urandom);
      ia     = 32'($urandom_range(0, 32'h1FFF));
      da     = 32'($urandom_range(0, 32'h1FFF));
      wr     = 1'($urandom);
      model(ia, 2, priv_u, i_ok, ik);
      model(da, int'(wr), priv_u, d_ok, dk);
      if ($urandom_range(0, 3) == 0)
        both(ia, da, wr, rr_m, i_ok, ik + 2, d_ok, dk + 2, "rnd_both");
      else begin
        side = 1'($urandom);
        if (side) single(1'b1, da, wr, d_ok, dk + 2, "rnd_d");
        else single(1'b0, ia, 1'b0, i_ok, ik + 2, "rnd_i");
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
